// File: rtl/ip_fp_pkg.sv
// Shared FP definitions: i2f FSM states, status bit indices,
// default FP16 format and FP16 zero/infinity encodings.
package ip_fp_pkg;

  localparam int DEF_EXP  = 5;
  localparam int DEF_FRAC = 10;
  localparam int DEF_BIAS = 15;

  localparam int ST_INEXACT = 0;
  localparam int ST_OVF     = 1;
  localparam int ST_ZERO    = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_NORM,
    S_ROUND,
    S_DONE
  } i2f_state_t;

  localparam logic [DEF_EXP+DEF_FRAC:0] FP16_ZERO = '0;
  localparam logic [DEF_EXP+DEF_FRAC:0] FP16_INF =
    {1'b0, {DEF_EXP{1'b1}}, {DEF_FRAC{1'b0}}};

endpackage

// File: rtl/ip_fp_i2f_seq_if.sv
// Handshake bundle for ip_fp_i2f_seq: input side (in_valid,
// in_ready, x) and output side (out_valid, out_ready, z, status).
interface ip_fp_i2f_seq_if #(
  parameter int P_INT  = 16,
  parameter int P_WORD = 16
);

  logic              in_valid;
  logic              in_ready;
  logic [P_INT-1:0]  x;
  logic              out_valid;
  logic              out_ready;
  logic [P_WORD-1:0] z;
  logic [7:0]        status;

  modport master (
    output in_valid, x, out_ready,
    input  in_ready, out_valid, z, status
  );

  modport slave (
    input  in_valid, x, out_ready,
    output in_ready, out_valid, z, status
  );

endinterface

// File: rtl/ip_fp_rnd_rne.sv
// Round-to-nearest-even on a normalized mantissa with overflow to inf.
// In: i_exp, i_mant, i_guard, i_sticky. Out: o_ef, o_inexact, o_overflow.
module ip_fp_rnd_rne
  import ip_fp_pkg::*;
#(
  parameter int P_EXP  = DEF_EXP,
  parameter int P_FRAC = DEF_FRAC,
  parameter int P_EW   = P_EXP + 2
) (
  input  logic [P_EW-1:0]         i_exp,
  input  logic [P_FRAC:0]         i_mant,
  input  logic                    i_guard,
  input  logic                    i_sticky,
  output logic [P_EXP+P_FRAC-1:0] o_ef,
  output logic                    o_inexact,
  output logic                    o_overflow
);

  localparam logic [P_EW-1:0] L_EMAX =
    P_EW'((1 << P_EXP) - 1);

  logic              w_inc;
  logic [P_FRAC+1:0] w_sum;
  logic              w_carry;
  logic [P_EW-1:0]   w_exp;
  logic [P_FRAC-1:0] w_frac;
  logic              w_unused;

  assign w_inc   = i_guard & (i_sticky | i_mant[0]);
  assign w_sum   = {1'b0, i_mant} + (P_FRAC+2)'(w_inc);
  assign w_carry = w_sum[P_FRAC+1];
  assign w_exp   = i_exp + P_EW'(w_carry);

  // carry-out means the mantissa became 10.00..0
  assign w_frac  = w_carry ? '0 : w_sum[P_FRAC-1:0];

  assign o_overflow = (w_exp >= L_EMAX);
  assign o_inexact  = i_guard | i_sticky | o_overflow;

  assign o_ef = o_overflow
    ? {{P_EXP{1'b1}}, {P_FRAC{1'b0}}}
    : {w_exp[P_EXP-1:0], w_frac};

  // hidden bit is implied, not stored
  assign w_unused = w_sum[P_FRAC];

endmodule

// File: rtl/ip_fp_i2f_seq.sv
// Iterative signed int to FP converter, one normalize bit per cycle.
// Ports: clk, rst, bus (slave). Macro IP_FP_I2F_STATUS_EN enables status.
module ip_fp_i2f_seq
  import ip_fp_pkg::*;
#(
  parameter int P_EXP  = DEF_EXP,
  parameter int P_FRAC = DEF_FRAC,
  parameter int P_BIAS = DEF_BIAS,
  parameter int P_WORD = 1 + P_FRAC + P_EXP,
  parameter int P_INT  = 16
) (
  input  logic           clk,
  input  logic           rst,
  ip_fp_i2f_seq_if.slave bus
);

  localparam int L_EW = $clog2(P_BIAS + P_INT) + 1;
  localparam logic [L_EW-1:0] L_EXP0 =
    L_EW'(P_BIAS + P_INT - 1);

  i2f_state_t        r_state;
  logic              r_in_ready;
  logic              r_out_valid;
  logic              r_sign;
  logic [P_INT-1:0]  r_mag;
  logic [L_EW-1:0]   r_exp;
  logic [P_WORD-1:0] r_z;

  logic [P_INT-1:0]  w_abs;
  logic [P_FRAC:0]   w_mant;
  logic              w_guard;
  logic              w_sticky;
  logic [P_WORD-2:0] w_ef;
  logic              w_inexact;
  logic              w_overflow;

  // -2^(P_INT-1) wraps to 2^(P_INT-1), valid as unsigned
  assign w_abs = bus.x[P_INT-1]
    ? ({P_INT{1'b0}} - bus.x) : bus.x;

  assign w_mant   = r_mag[P_INT-1 -: P_FRAC+1];
  assign w_guard  = r_mag[P_INT-P_FRAC-2];
  assign w_sticky = |(r_mag << (P_FRAC + 2));

  ip_fp_rnd_rne #(
    .P_EXP  (P_EXP),
    .P_FRAC (P_FRAC),
    .P_EW   (L_EW)
  ) u_rnd (
    .i_exp      (r_exp),
    .i_mant     (w_mant),
    .i_guard    (w_guard),
    .i_sticky   (w_sticky),
    .o_ef       (w_ef),
    .o_inexact  (w_inexact),
    .o_overflow (w_overflow)
  );

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.z         = r_z;

`ifdef IP_FP_I2F_STATUS_EN
  logic [7:0] r_status;
  assign bus.status = r_status;
`else
  logic w_unused;
  assign bus.status = 8'h00;
  assign w_unused   = w_inexact ^ w_overflow;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_sign      <= 1'b0;
      r_mag       <= '0;
      r_exp       <= '0;
      r_z         <= '0;
`ifdef IP_FP_I2F_STATUS_EN
      r_status    <= '0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_sign     <= bus.x[P_INT-1];
            r_mag      <= w_abs;
            r_exp      <= L_EXP0;
            r_in_ready <= 1'b0;
            if (w_abs == '0) begin
              r_z         <= '0;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
`ifdef IP_FP_I2F_STATUS_EN
              r_status          <= '0;
              r_status[ST_ZERO] <= 1'b1;
`endif
            end else begin
              r_state <= S_NORM;
            end
          end
        end
        S_NORM: begin
          if (r_mag[P_INT-1]) begin
            r_state <= S_ROUND;
          end else begin
            r_mag <= r_mag << 1;
            r_exp <= r_exp - L_EW'(1);
          end
        end
        S_ROUND: begin
          r_z         <= {r_sign, w_ef};
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
`ifdef IP_FP_I2F_STATUS_EN
          r_status             <= '0;
          r_status[ST_INEXACT] <= w_inexact;
          r_status[ST_OVF]     <= w_overflow;
`endif
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ip_fp_i2f_seq.sv
// Bench for ip_fp_i2f_seq: 16-bit and 32-bit input instances,
// scoreboard queue of expected z/status/latency per conversion.
module tb_ip_fp_i2f_seq;

`ifdef IP_FP_I2F_STATUS_EN
  localparam logic [7:0] ST_MASK = 8'hFF;
`else
  localparam logic [7:0] ST_MASK = 8'h00;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  ip_fp_i2f_seq_if #(.P_INT(16), .P_WORD(16)) b16 ();
  ip_fp_i2f_seq_if #(.P_INT(32), .P_WORD(16)) b32 ();

  ip_fp_i2f_seq #(.P_INT(16)) u_dut16 (
    .clk (clk),
    .rst (rst),
    .bus (b16)
  );

  ip_fp_i2f_seq #(.P_INT(32)) u_dut32 (
    .clk (clk),
    .rst (rst),
    .bus (b32)
  );

  bit          cur = 1'b0;
  logic        m_ov, m_ir;
  logic [15:0] m_z;
  logic [7:0]  m_st;

  assign m_ov = cur ? b32.out_valid : b16.out_valid;
  assign m_ir = cur ? b32.in_ready  : b16.in_ready;
  assign m_z  = cur ? b32.z         : b16.z;
  assign m_st = cur ? b32.status    : b16.status;

  typedef struct {
    logic [15:0] z;
    logic [7:0]  st;
    int          lat;
  } exp_t;

  exp_t sb[$];

  task automatic set_in(input bit sel, input logic v,
                        input logic [31:0] xv);
    if (sel) begin
      b32.in_valid = v;
      b32.x        = xv;
    end else begin
      b16.in_valid = v;
      b16.x        = xv[15:0];
    end
  endtask

  task automatic push(input logic [15:0] z, input logic [7:0] st,
                      input int lat);
    exp_t e;
    e.z   = z;
    e.st  = st & ST_MASK;
    e.lat = lat;
    sb.push_back(e);
  endtask

  // drive one op, return outputs when out_valid is seen (lat=-1 on timeout)
  task automatic run_op(input bit sel, input logic [31:0] xv,
                        output logic [15:0] oz, output logic [7:0] ost,
                        output int lat, output logic oir);
    int g;
    cur = sel;
    @(negedge clk);
    set_in(sel, 1'b1, xv);
    g = 0;
    while (!m_ir && g < 50) begin
      @(negedge clk);
      g++;
    end
    @(posedge clk);
    lat = -1;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      if (n == 1) set_in(sel, 1'b0, '0);
      if (m_ov) begin
        lat = n;
        break;
      end
    end
    oz  = m_z;
    ost = m_st;
    oir = m_ir;
  endtask

  task automatic test_reset();
    b16.out_ready = 1'b1;
    b32.out_ready = 1'b1;
    set_in(1'b0, 1'b1, 32'd5);
    set_in(1'b1, 1'b1, 32'd5);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks += 8;
    if (b16.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst16_in_ready got=%b exp=1", b16.in_ready);
    end
    if (b16.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst16_out_valid got=%b exp=0", b16.out_valid);
    end
    if (b16.z !== 16'h0000) begin
      failures++;
      $display("FAIL rst16_z got=%h exp=0000", b16.z);
    end
    if (b16.status !== 8'h00) begin
      failures++;
      $display("FAIL rst16_status got=%h exp=00", b16.status);
    end
    if (b32.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst32_in_ready got=%b exp=1", b32.in_ready);
    end
    if (b32.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst32_out_valid got=%b exp=0", b32.out_valid);
    end
    if (b32.z !== 16'h0000) begin
      failures++;
      $display("FAIL rst32_z got=%h exp=0000", b32.z);
    end
    if (b32.status !== 8'h00) begin
      failures++;
      $display("FAIL rst32_status got=%h exp=00", b32.status);
    end
    set_in(1'b0, 1'b0, '0);
    set_in(1'b1, 1'b0, '0);
    rst = 1'b0;
  endtask

  task automatic run_table(input string name, input bit sel,
                           input logic [31:0] tx[],
                           input logic [15:0] tz[],
                           input logic [7:0] ts[], input int tl[]);
    logic [15:0] oz;
    logic [7:0]  ost;
    int          lat;
    logic        oir;
    exp_t        e;
    foreach (tx[i]) begin
      push(tz[i], ts[i], tl[i]);
      run_op(sel, tx[i], oz, ost, lat, oir);
      e = sb.pop_front();
      checks += 4;
      if (oz !== e.z) begin
        failures++;
        $display("FAIL %s[%0d] z got=%h exp=%h", name, i, oz, e.z);
      end
      if (ost !== e.st) begin
        failures++;
        $display("FAIL %s[%0d] status got=%h exp=%h",
                 name, i, ost, e.st);
      end
      if (lat != e.lat) begin
        failures++;
        $display("FAIL %s[%0d] latency got=%0d exp=%0d",
                 name, i, lat, e.lat);
      end
      if (oir !== 1'b0) begin
        failures++;
        $display("FAIL %s[%0d] in_ready_in_done got=%b exp=0",
                 name, i, oir);
      end
    end
  endtask

  task automatic test_convert16();
    logic [31:0] tx[];
    logic [15:0] tz[];
    logic [7:0]  ts[];
    int          tl[];
    tx = '{32'd1, 32'hFFFF_8000, 32'hFFFF_FFFF, 32'd2049,
           32'd2051, 32'd0, 32'd32767};
    tz = '{16'h3C00, 16'hF800, 16'hBC00, 16'h6800,
           16'h6802, 16'h0000, 16'h7800};
    ts = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h04, 8'h01};
    tl = '{18, 3, 18, 7, 7, 1, 4};
    run_table("conv16", 1'b0, tx, tz, ts, tl);
  endtask

  task automatic test_convert32();
    logic [31:0] tx[];
    logic [15:0] tz[];
    logic [7:0]  ts[];
    int          tl[];
    tx = '{32'd65520, 32'd65504, 32'hFFFF_0000, 32'd1};
    tz = '{16'h7C00, 16'h7BFF, 16'hFC00, 16'h3C00};
    ts = '{8'h03, 8'h00, 8'h03, 8'h00};
    tl = '{19, 19, 18, 34};
    run_table("conv32", 1'b1, tx, tz, ts, tl);
  endtask

  task automatic test_backpressure();
    logic [15:0] oz;
    logic [7:0]  ost;
    int          lat;
    logic        oir;
    exp_t        e;
    b16.out_ready = 1'b0;
    push(16'h4500, 8'h00, 16);
    run_op(1'b0, 32'd5, oz, ost, lat, oir);
    e = sb.pop_front();
    checks += 2;
    if (oz !== e.z) begin
      failures++;
      $display("FAIL bp z got=%h exp=%h", oz, e.z);
    end
    if (lat != e.lat) begin
      failures++;
      $display("FAIL bp latency got=%0d exp=%0d", lat, e.lat);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks += 3;
      if (m_ov !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold[%0d] out_valid got=%b exp=1", i, m_ov);
      end
      if (m_z !== e.z) begin
        failures++;
        $display("FAIL bp_hold[%0d] z got=%h exp=%h", i, m_z, e.z);
      end
      if (m_ir !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold[%0d] in_ready got=%b exp=0", i, m_ir);
      end
    end
    b16.out_ready = 1'b1;
    @(negedge clk);
    checks += 2;
    if (m_ov !== 1'b0) begin
      failures++;
      $display("FAIL bp_release out_valid got=%b exp=0", m_ov);
    end
    if (m_ir !== 1'b1) begin
      failures++;
      $display("FAIL bp_release in_ready got=%b exp=1", m_ir);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] oz;
    logic [7:0]  ost;
    int          lat;
    logic        oir;
    int          seen;
    exp_t        e;
    cur  = 1'b0;
    seen = 0;
    @(negedge clk);
    set_in(1'b0, 1'b1, 32'd1);
    @(posedge clk);
    @(negedge clk);
    set_in(1'b0, 1'b0, '0);
    repeat (4) begin
      @(negedge clk);
      if (m_ov) seen++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks += 1;
    if (m_ir !== 1'b1) begin
      failures++;
      $display("FAIL rstmid in_ready got=%b exp=1", m_ir);
    end
    repeat (25) begin
      @(negedge clk);
      if (m_ov) seen++;
    end
    checks += 1;
    if (seen != 0) begin
      failures++;
      $display("FAIL rstmid out_valid_cycles got=%0d exp=0", seen);
    end
    push(16'h6802, 8'h01, 7);
    run_op(1'b0, 32'd2051, oz, ost, lat, oir);
    e = sb.pop_front();
    checks += 3;
    if (oz !== e.z) begin
      failures++;
      $display("FAIL rstmid_next z got=%h exp=%h", oz, e.z);
    end
    if (ost !== e.st) begin
      failures++;
      $display("FAIL rstmid_next status got=%h exp=%h", ost, e.st);
    end
    if (lat != e.lat) begin
      failures++;
      $display("FAIL rstmid_next latency got=%0d exp=%0d",
               lat, e.lat);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_convert16();
    test_convert32();
    test_backpressure();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
